// File: rtl/core_inst_seq.sv
// Instruction sequencer for one convolution layer: it produces the registered
// 50-bit inst word that drives core through weight, activation, execute and OFIFO phases.
module core_inst_seq #(
  parameter int unsigned COL      = 8,
  parameter int unsigned LEN_NIJ  = 16,
  parameter int unsigned LEN_ONIJ = 16,
  parameter int unsigned LEN_KIJ  = 9,
  parameter logic [10:0] ACT_BASE = 11'h000,
  parameter logic [10:0] WGT_BASE = 11'h400,
  parameter int unsigned GAP      = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  input  logic        l0_ready,
  output logic [49:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx
);

  localparam int unsigned CNT_MAX = (COL > LEN_NIJ) ? ((COL > GAP) ? COL : GAP)
                                                    : ((LEN_NIJ > GAP) ? LEN_NIJ : GAP);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ON_W    = $clog2(LEN_ONIJ + 1);
  localparam int unsigned KIJ_W   = 4;
  localparam logic [49:0] IDLE_INST = 50'h1_8001_0018_0000;

  typedef struct packed {
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [13:0] a_pmem;
    logic        cen1_xmem;
    logic [10:0] a1_xmem;
    logic        cen0_xmem;
    logic        wen0_xmem;
    logic [10:0] a0_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        mode;
    logic        execute;
    logic        load;
  } inst_t;

  typedef enum logic [2:0] {
    S_IDLE, S_W_WAIT, S_W_L0, S_A_EXEC, S_DRAIN, S_GAP, S_O_RD, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ON_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ON_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic              pend_q, pend_d;
  logic [KIJ_W-1:0]  kij_q, kij_d;

  inst_t             inst_q, inst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [KIJ_W-1:0]  kij_idx_q, kij_idx_d;

  logic              rd_fire;
  logic              last_wr;

  // An OFIFO read is issued only while reads remain; its pmem write follows a cycle later.
  assign rd_fire = (state_q == S_O_RD) && ofifo_valid && (rd_cnt_q < ON_W'(LEN_ONIJ));
  assign last_wr = pend_q && (wr_cnt_q == ON_W'(LEN_ONIJ - 1));

  // State and counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      pend_q   <= 1'b0;
      kij_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      pend_q   <= pend_d;
      kij_q    <= kij_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    pend_d   = 1'b0;
    kij_d    = kij_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_W_WAIT;
        cnt_d   = '0;
        kij_d   = '0;
      end
      S_W_WAIT: if (l0_ready) begin
        state_d = S_W_L0;
        cnt_d   = '0;
      end
      S_W_L0: if (cnt_q == CNT_W'(COL)) begin
        state_d = S_A_EXEC;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_A_EXEC: if (cnt_q == CNT_W'(LEN_NIJ)) begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_DRAIN: if (cnt_q == CNT_W'(COL - 1)) begin
        state_d = S_GAP;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_GAP: if (cnt_q == CNT_W'(GAP - 1)) begin
        state_d  = S_O_RD;
        cnt_d    = '0;
        rd_cnt_d = '0;
        wr_cnt_d = '0;
      end else cnt_d = cnt_q + CNT_W'(1);
      S_O_RD: begin
        pend_d = rd_fire;
        if (rd_fire) rd_cnt_d = rd_cnt_q + ON_W'(1);
        if (pend_q)  wr_cnt_d = wr_cnt_q + ON_W'(1);
        if (last_wr) begin
          if (kij_q == KIJ_W'(LEN_KIJ - 1)) state_d = S_FIN;
          else begin
            state_d = S_W_WAIT;
            kij_d   = kij_q + KIJ_W'(1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        kij_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; every value decided here lands on the outputs next cycle
  always_comb begin
    inst_d    = IDLE_INST;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_FIN);
    kij_idx_d = (state_q == S_FIN) ? '0 : kij_q;
    case (state_q)
      S_W_L0: begin
        inst_d.l0_wr = (cnt_q != '0);
        if (cnt_q < CNT_W'(COL)) begin
          inst_d.cen0_xmem = 1'b0;
          inst_d.a0_xmem   = WGT_BASE + 11'(kij_q) * 11'(COL) + 11'(cnt_q);
        end
      end
      S_A_EXEC: begin
        inst_d.l0_wr   = (cnt_q != '0);
        inst_d.l0_rd   = (cnt_q != '0);
        inst_d.load    = (cnt_q != '0) && (cnt_q <= CNT_W'(COL));
        inst_d.execute = (cnt_q > CNT_W'(COL));
        if (cnt_q < CNT_W'(LEN_NIJ)) begin
          inst_d.cen0_xmem = 1'b0;
          inst_d.a0_xmem   = ACT_BASE + 11'(cnt_q);
        end
      end
      S_DRAIN: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
      end
      S_O_RD: begin
        inst_d.ofifo_rd = rd_fire;
        if (pend_q) begin
          inst_d.cen_pmem = 1'b0;
          inst_d.wen_pmem = 1'b0;
          inst_d.a_pmem   = 14'(kij_q) * 14'(LEN_ONIJ) + 14'(wr_cnt_q);
        end
      end
      default: ;
    endcase
  end

  // Output register
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q    <= IDLE_INST;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      kij_idx_q <= '0;
    end else begin
      inst_q    <= inst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      kij_idx_q <= kij_idx_d;
    end
  end

  assign inst    = inst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign kij_idx = kij_idx_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: a cycle schedule of inputs and expected outputs is
// built from the layer description, then replayed against the DUT.
module tb_core_inst_seq;

  localparam logic [49:0] IDLE_INST = 50'h1_8001_0018_0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic        l0_ready;
  logic [49:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  core_inst_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ofifo_valid(ofifo_valid),
    .l0_ready   (l0_ready),
    .inst       (inst),
    .busy       (busy),
    .done       (done),
    .kij_idx    (kij_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          st;
    bit          l0;
    bit          ov;
    logic [49:0] inst;
    bit          busy;
    bit          done;
    logic [3:0]  kij;
  } ent_t;

  ent_t        sched[$];
  logic [49:0] pins[int];
  int          n_chk  = 0;
  int          n_err  = 0;
  int          n_done = 0;

  function automatic logic [49:0] mk(input bit cen0, input logic [10:0] a0, input bit l0_wr,
                                     input bit l0_rd, input bit ld, input bit ex,
                                     input bit ofrd, input bit pm, input logic [13:0] apm);
    logic [49:0] w;
    w       = IDLE_INST;
    w[20]   = cen0;
    w[18:8] = a0;
    w[3]    = l0_wr;
    w[4]    = l0_rd;
    w[0]    = ld;
    w[1]    = ex;
    w[7]    = ofrd;
    if (pm) begin
      w[48]    = 1'b0;
      w[47]    = 1'b0;
      w[46:33] = apm;
    end
    return w;
  endfunction

  function automatic bit ov_pat(input int k, input int j);
    if (k == 2) return (j % 2) == 0;
    if (k == 4) return j >= 3;
    if (k == 6) return (j % 3) != 1;
    return 1'b1;
  endfunction

  task automatic push(input bit rst, input bit st, input bit l0, input bit ov,
                      input logic [49:0] w, input bit b, input bit d, input logic [3:0] k);
    ent_t e;
    e.rst  = rst;
    e.st   = st;
    e.l0   = l0;
    e.ov   = ov;
    e.inst = w;
    e.busy = b;
    e.done = d;
    e.kij  = k;
    sched.push_back(e);
  endtask

  task automatic idle_cycles(input int n, input bit rst);
    for (int i = 0; i < n; i++) push(rst, 1'b0, 1'b1, 1'b1, IDLE_INST, 1'b0, 1'b0, 4'd0);
  endtask

  // One layer of 9 kernel passes; optionally cut short by reset in A_EXEC.
  task automatic gen_layer(input int abort_kij, input int abort_n, input bit pin_en);
    int r;
    int wi;
    int wt;
    bit pend;
    bit v;
    bit rd;
    bit lastw;
    push(1'b0, 1'b1, 1'b1, 1'b1, IDLE_INST, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 9; k++) begin
      wt = (k == 1) ? 5 : 0;
      for (int w = 0; w <= wt; w++)
        push(1'b0, (k == 3 && w == 0), (w == wt), 1'b1, IDLE_INST, 1'b1, 1'b0, 4'(k));
      for (int c = 0; c <= 8; c++) begin
        push(1'b0, 1'b0, 1'b1, 1'b1,
             mk(c == 8, (c < 8) ? 11'(1024 + k * 8 + c) : 11'h0, c > 0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0), 1'b1, 1'b0, 4'(k));
        if (pin_en && k == 0 && c == 0) pins[sched.size() - 1] = 50'h1_8001_000C_0000;
        if (pin_en && k == 1 && c == 7) pins[sched.size() - 1] = 50'h1_8001_000C_0F08;
      end
      for (int n = 0; n <= 16; n++) begin
        if (k == abort_kij && n == abort_n) begin
          push(1'b1, 1'b0, 1'b1, 1'b1, IDLE_INST, 1'b0, 1'b0, 4'd0);
          return;
        end
        push(1'b0, 1'b0, 1'b1, 1'b1,
             mk(n == 16, (n < 16) ? 11'(n) : 11'h0, n > 0, n > 0,
                (n >= 1 && n <= 8), n > 8, 1'b0, 1'b0, 14'h0), 1'b1, 1'b0, 4'(k));
        if (pin_en && k == 0 && n == 1) pins[sched.size() - 1] = 50'h1_8001_0008_0119;
      end
      for (int i = 0; i < 8; i++) begin
        push(1'b0, 1'b0, 1'b1, 1'b1,
             mk(1'b1, 11'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0), 1'b1, 1'b0, 4'(k));
        if (pin_en && k == 0 && i == 0) pins[sched.size() - 1] = 50'h1_8001_0018_0012;
      end
      for (int g = 0; g < 10; g++)
        push(1'b0, (k == 0 && g == 3), 1'b1, 1'b1, IDLE_INST, 1'b1, 1'b0, 4'(k));
      r = 0;
      wi = 0;
      pend = 1'b0;
      for (int j = 0; j < 200; j++) begin
        v     = ov_pat(k, j);
        rd    = v && (r < 16);
        lastw = pend && (wi == 15);
        push(1'b0, 1'b0, 1'b1, v,
             mk(1'b1, 11'h0, 1'b0, 1'b0, 1'b0, 1'b0, rd, pend, 14'(k * 16 + wi)),
             1'b1, 1'b0, 4'(k));
        if (pin_en && lastw && k == 8) pins[sched.size() - 1] = 50'h0_011F_0018_0000;
        if (pend) wi++;
        if (rd) r++;
        pend = rd;
        if (lastw) break;
      end
    end
    push(1'b0, 1'b0, 1'b1, 1'b1, IDLE_INST, 1'b0, 1'b1, 4'd0);
  endtask

  task automatic cmp(input string name, input int t, input logic [49:0] got, input logic [49:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %h expected %h", name, t, got, exp);
    end
  endtask

  task automatic check(input int t, input ent_t e);
    cmp("inst", t, inst, e.inst);
    cmp("busy", t, 50'(busy), 50'(e.busy));
    cmp("done", t, 50'(done), 50'(e.done));
    cmp("kij_idx", t, 50'(kij_idx), 50'(e.kij));
    if (pins.exists(t)) cmp("inst_literal", t, inst, pins[t]);
    if (done === 1'b1) n_done++;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    ofifo_valid = 1'b0;
    l0_ready    = 1'b0;

    idle_cycles(10, 1'b1);
    idle_cycles(5, 1'b0);
    gen_layer(-1, 0, 1'b1);
    idle_cycles(6, 1'b0);
    gen_layer(3, 5, 1'b0);
    idle_cycles(4, 1'b0);
    gen_layer(0, 2, 1'b0);
    idle_cycles(3, 1'b0);

    for (int t = 0; t < sched.size(); t++) begin
      @(negedge clk);
      if (t > 0) check(t - 1, sched[t - 1]);
      reset       = sched[t].rst;
      start       = sched[t].st;
      l0_ready    = sched[t].l0;
      ofifo_valid = sched[t].ov;
    end
    @(negedge clk);
    check(sched.size() - 1, sched[sched.size() - 1]);

    cmp("done_pulse_count", -1, 50'(n_done), 50'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
